// File: rtl/conv_ctrl.sv
// Sequencer for a K-tap sliding-window datapath: streams an IMG_N x IMG_N image row by row and emits one window sum per valid position.
// Optional macro CONV_CTRL_STALL_CNT_EN enables the saturating back-pressure counter on stall_cnt.
module conv_ctrl #(
   parameter int DATA_W = 16,
   parameter int IMG_N  = 6,
   parameter int K      = 3,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              conv_rst,
   output logic              conv_en,
   output logic [DATA_W-1:0] conv_pixel,
   input  logic [DATA_W-1:0] conv_out,
   input  logic              conv_valid,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [7:0]        res_row,
   output logic [7:0]        res_col,
   output logic [15:0]       stall_cnt
);

   typedef enum logic [2:0] {IDLE, FETCH, FEED, WAIT, OUT, DONE} state_t;

   localparam logic [7:0] FLUSH_COL = 8'(IMG_N);
   localparam logic [7:0] LAST_ROW  = 8'(IMG_N - 1);
   localparam logic [7:0] FIRST_E   = 8'(K + 1);
   localparam logic [7:0] FLUSH_E   = 8'(IMG_N + 1);

   state_t            state, state_nxt;
   logic [7:0]        row, row_nxt;
   logic [7:0]        col, col_nxt;
   logic [7:0]        e, e_nxt;
   logic              res_valid_q, res_valid_nxt;
   logic [DATA_W-1:0] res_data_q, res_data_nxt;
   logic [7:0]        res_row_q, res_row_nxt;
   logic [7:0]        res_col_q, res_col_nxt;
   logic              advance;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         row         <= '0;
         col         <= '0;
         e           <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_row_q   <= '0;
         res_col_q   <= '0;
      end else begin
         state       <= state_nxt;
         row         <= row_nxt;
         col         <= col_nxt;
         e           <= e_nxt;
         res_valid_q <= res_valid_nxt;
         res_data_q  <= res_data_nxt;
         res_row_q   <= res_row_nxt;
         res_col_q   <= res_col_nxt;
      end
   end

   // Column IMG_N is a pseudo-column: a zero pixel that flushes the row's last window out of the datapath.
   always_comb begin
      state_nxt     = state;
      row_nxt       = row;
      col_nxt       = col;
      e_nxt         = e;
      res_valid_nxt = res_valid_q;
      res_data_nxt  = res_data_q;
      res_row_nxt   = res_row_q;
      res_col_nxt   = res_col_q;
      busy          = (state != IDLE);
      done          = 1'b0;
      mem_rd_en     = 1'b0;
      mem_addr      = '0;
      conv_rst      = 1'b0;
      conv_en       = 1'b0;
      conv_pixel    = '0;
      advance       = 1'b0;

      case (state)
         IDLE: begin
            if (start && rst_n) begin
               row_nxt   = '0;
               col_nxt   = '0;
               e_nxt     = '0;
               conv_rst  = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            mem_rd_en = 1'b1;
            mem_addr  = ADDR_W'(32'(row) * IMG_N + 32'(col));
            state_nxt = FEED;
         end
         FEED: begin
            conv_en = 1'b1;
            if (col == FLUSH_COL) begin
               e_nxt = FLUSH_E;
            end else begin
               conv_pixel = mem_rdata;
               e_nxt      = e + 8'd1;
            end
            state_nxt = WAIT;
         end
         WAIT: begin
            // The first K enables of a row hold stale or cross-row windows and are dropped.
            if (e >= FIRST_E && conv_valid) begin
               res_valid_nxt = 1'b1;
               res_data_nxt  = conv_out;
               res_row_nxt   = row;
               res_col_nxt   = e - FIRST_E;
               state_nxt     = OUT;
            end else begin
               advance = 1'b1;
            end
         end
         OUT: begin
            if (res_ready) begin
               res_valid_nxt = 1'b0;
               advance       = 1'b1;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (advance) begin
         if (col == FLUSH_COL) begin
            if (row < LAST_ROW) begin
               row_nxt   = row + 8'd1;
               col_nxt   = '0;
               e_nxt     = '0;
               state_nxt = FETCH;
            end else begin
               state_nxt = DONE;
            end
         end else begin
            col_nxt   = col + 8'd1;
            state_nxt = (col + 8'd1 == FLUSH_COL) ? FEED : FETCH;
         end
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_row   = res_row_q;
   assign res_col   = res_col_q;

`ifdef CONV_CTRL_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (state == IDLE && start) begin
         stall_q <= '0;
      end else if (state == OUT && !res_ready && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_ctrl.sv
// Bench for conv_ctrl: behavioural image memory and window-sum datapath, expected results computed directly from the image.
module tb_conv_ctrl;

   localparam int DATA_W = 16;
   localparam int IMG_N  = 6;
   localparam int K      = 3;
   localparam int ADDR_W = 6;
   localparam int BUDGET = 3000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              busy;
   logic              done;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              conv_rst;
   logic              conv_en;
   logic [DATA_W-1:0] conv_pixel;
   logic [DATA_W-1:0] conv_out;
   logic              conv_valid;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;
   logic [7:0]        res_row;
   logic [7:0]        res_col;
   logic [15:0]       stall_cnt;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] mem [IMG_N*IMG_N];
   logic [DATA_W-1:0] win [K];

   typedef struct {
      int          row;
      int          col;
      logic [15:0] data;
   } res_t;

   res_t expQ[$];

   conv_ctrl #(.DATA_W(DATA_W), .IMG_N(IMG_N), .K(K), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .conv_rst(conv_rst), .conv_en(conv_en), .conv_pixel(conv_pixel),
      .conv_out(conv_out), .conv_valid(conv_valid),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_row(res_row), .res_col(res_col), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Image memory with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   function automatic logic [DATA_W-1:0] win_sum();
      logic [DATA_W-1:0] s = '0;
      for (int k = 0; k < K; k++) s = s + win[k];
      return s;
   endfunction

   // Datapath registers the sum of the window held before each shift, so an enable reports the previous window.
   always @(posedge clk) begin
      if (conv_rst) begin
         for (int k = 0; k < K; k++) win[k] <= '0;
         conv_out   <= '0;
         conv_valid <= 1'b0;
      end else if (conv_en) begin
         conv_out <= win_sum();
         for (int k = K - 1; k > 0; k--) win[k] <= win[k-1];
         win[0]     <= conv_pixel;
         conv_valid <= 1'b1;
      end else begin
         conv_valid <= 1'b0;
      end
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check_output({tag, "_busy"}, busy, 0);
      check_output({tag, "_done"}, done, 0);
      check_output({tag, "_mem_rd_en"}, mem_rd_en, 0);
      check_output({tag, "_conv_en"}, conv_en, 0);
      check_output({tag, "_conv_rst"}, conv_rst, 0);
      check_output({tag, "_res_valid"}, res_valid, 0);
      check_output({tag, "_mem_addr"}, mem_addr, 0);
      check_output({tag, "_conv_pixel"}, conv_pixel, 0);
      check_output({tag, "_res_data"}, res_data, 0);
      check_output({tag, "_res_row"}, res_row, 0);
      check_output({tag, "_res_col"}, res_col, 0);
      check_output({tag, "_stall_cnt"}, stall_cnt, 0);
   endtask

   // Every K-wide horizontal window of every row, row-major, columns ascending, wrapped to DATA_W bits.
   task automatic build_expected();
      expQ.delete();
      for (int r = 0; r < IMG_N; r++) begin
         for (int c = 0; c <= IMG_N - K; c++) begin
            int unsigned s = 0;
            for (int j = 0; j < K; j++) s += mem[r*IMG_N + c + j];
            expQ.push_back('{row: r, col: c, data: 16'(s)});
         end
      end
   endtask

   // readyMode: 0 always ready, 1 random ready, 2 hold off the first result for five cycles.
   task automatic apply_stimulus(input string name, input int readyMode, input int restartAt, input int resetAt);
      int          cyc = 0;
      int          firstCyc = -1;
      int          doneCnt = 0;
      int          resIdx = 0;
      int          stallExp = 0;
      int          holdCnt = 0;
      int          stallLeft = 5;
      bit          prevStall = 0;
      bit          finished = 0;
      logic [15:0] prevData = '0;
      logic [7:0]  prevRow = '0;
      logic [7:0]  prevCol = '0;

      build_expected();
      @(negedge clk);
      start     = 1'b1;
      res_ready = 1'b1;
      #1 check_output({name, "_conv_rst"}, conv_rst, 1);
      @(negedge clk);
      start = 1'b0;

      while (cyc < BUDGET) begin
         if (doneCnt > 0) begin
            check_output({name, "_busy_after_done"}, busy, 0);
            finished = 1;
            break;
         end
         check_output({name, "_en_overlap"}, conv_en & mem_rd_en, 0);
         if (prevStall) begin
            check_output({name, "_hold_valid"}, res_valid, 1);
            check_output({name, "_hold_data"}, res_data, prevData);
            check_output({name, "_hold_row"}, res_row, prevRow);
            check_output({name, "_hold_col"}, res_col, prevCol);
         end
         if (res_valid && firstCyc < 0) firstCyc = cyc + 1;
         if (res_valid && resIdx == 0) holdCnt++;
         if (done) doneCnt++;

         case (readyMode)
            1:       res_ready = 1'($urandom_range(0, 1));
            2: begin
               res_ready = !(res_valid && resIdx == 0 && stallLeft > 0);
               if (!res_ready) stallLeft--;
            end
            default: res_ready = 1'b1;
         endcase

         if (res_valid && !res_ready) stallExp++;
         if (res_valid && res_ready) begin
            if (resIdx < expQ.size()) begin
               check_output({name, "_data"}, res_data, expQ[resIdx].data);
               check_output({name, "_row"}, res_row, expQ[resIdx].row);
               check_output({name, "_col"}, res_col, expQ[resIdx].col);
            end else begin
               check_output({name, "_extra_result"}, resIdx, expQ.size() - 1);
            end
            resIdx++;
         end
         prevStall = res_valid && !res_ready;
         prevData  = res_data;
         prevRow   = res_row;
         prevCol   = res_col;

         start = (cyc == restartAt);
         if (cyc == resetAt) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check_idle({name, "_after_reset"});
            check_output({name, "_no_done"}, doneCnt, 0);
            return;
         end
         @(negedge clk);
         cyc++;
      end

      start = 1'b0;
      check_output({name, "_finished"}, finished, 1);
      check_output({name, "_result_count"}, resIdx, expQ.size());
      check_output({name, "_done_count"}, doneCnt, 1);
      check_output({name, "_first_valid_cycle"}, firstCyc, 13);
      if (readyMode == 2) check_output({name, "_first_hold_cycles"}, holdCnt, 6);
`ifdef CONV_CTRL_STALL_CNT_EN
      check_output({name, "_stall_cnt"}, stall_cnt, stallExp);
`else
      check_output({name, "_stall_cnt"}, stall_cnt, 0);
`endif
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      res_ready = 1'b0;
      for (int a = 0; a < IMG_N*IMG_N; a++) mem[a] = DATA_W'(a);
      repeat (2) @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;

      apply_stimulus("ramp", 0, -1, -1);
      apply_stimulus("stall", 2, -1, -1);
      apply_stimulus("restart", 0, 20, -1);
      apply_stimulus("abort", 0, -1, 40);
      apply_stimulus("fresh", 0, -1, -1);

      for (int a = 0; a < IMG_N*IMG_N; a++) mem[a] = 16'hFFFF;
      apply_stimulus("ones", 0, -1, -1);

      for (int t = 0; t < 3; t++) begin
         for (int a = 0; a < IMG_N*IMG_N; a++) mem[a] = DATA_W'($urandom);
         apply_stimulus("rand", 1, -1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
